// File: rtl/color_result_stabilizer_if.sv
// Processor-side publish port of color_result_stabilizer: published result, valid/ack
// handshake and sticky overrun status with its clear strobe.
interface color_result_stabilizer_if;
    // o_valid rises on the cycle after a publish and holds until i_ack is sampled
    // while o_valid is high. A publish coinciding with i_ack keeps o_valid high,
    // because the newly published result has not been acknowledged yet.
    logic [31:0] o_result_stable;
    logic        o_valid;
    logic        o_overrun;
    logic        i_ack;
    logic        i_clr_overrun;

    modport master (
        output o_result_stable, o_valid, o_overrun,
        input  i_ack, i_clr_overrun
    );

    modport slave (
        input  o_result_stable, o_valid, o_overrun,
        output i_ack, i_clr_overrun
    );
endinterface

// File: rtl/color_result_stabilizer.sv
// Debounces the nine-region colour result across camera frames and publishes it.
// Optional macro STABILIZER_NOMATCH_REJECT_EN rejects snapshots containing region code 3'b111.
module color_result_stabilizer #(
    parameter int STABLE_FRAMES = 4,
    parameter int FCNT_WIDTH    = 16
) (
    input  logic                      i_clk_125MHz,
    input  logic                      db_rstn,
    input  logic                      i_sof,
    input  logic [31:0]               i_result,
    input  logic                      i_enable,
    color_result_stabilizer_if.master pub,
    output logic [FCNT_WIDTH-1:0]     o_frame_count,
    output logic [1:0]                o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1
    } state_e;

    localparam logic [7:0] SF = 8'(STABLE_FRAMES);

    state_e                  state_q, state_d;
    logic [26:0]             cand_q, cand_d;
    logic [7:0]              match_q, match_d;
    logic                    pub_q, pub_d;
    logic [26:0]             stable_q, stable_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [FCNT_WIDTH-1:0]   fcnt_q, fcnt_d;
    logic                    publish;
    logic                    snap_reject;
    logic [26:0]             snap;
    logic                    unused_padding;

    assign snap           = i_result[31:5];
    assign unused_padding = ^i_result[4:0];

`ifdef STABILIZER_NOMATCH_REJECT_EN
    always_comb begin
        snap_reject = 1'b0;
        for (int r = 0; r < 9; r++) begin
            if (snap[r*3 +: 3] == 3'b111) snap_reject = 1'b1;
        end
    end
`else
    assign snap_reject = 1'b0;
`endif

    // Tracking FSM: candidate/match bookkeeping and publish decision on each sof.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        pub_d   = pub_q;
        fcnt_d  = fcnt_q;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    match_d = 8'd0;
                    pub_d   = 1'b0;
                end else if (i_sof) begin
                    fcnt_d = fcnt_q + FCNT_WIDTH'(1);
                    if (snap_reject) begin
                        match_d = 8'd0;
                    end else if (snap == cand_q && match_q != 8'd0) begin
                        match_d = (match_q >= SF) ? SF : match_q + 8'd1;
                    end else begin
                        cand_d  = snap;
                        match_d = 8'd1;
                    end
                    publish = !snap_reject && (match_d == SF) &&
                              (!pub_q || cand_d != stable_q);
                    if (publish) pub_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Publish wins over a simultaneous ack, and overrun set wins over its clear.
    always_comb begin
        stable_d  = publish ? cand_d : stable_q;
        valid_d   = publish ? 1'b1 : (pub.i_ack ? 1'b0 : valid_q);
        overrun_d = (publish && valid_q) ? 1'b1 :
                    (pub.i_clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge i_clk_125MHz or negedge db_rstn) begin
        if (!db_rstn) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            match_q   <= '0;
            pub_q     <= 1'b0;
            stable_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            pub_q     <= pub_d;
            stable_q  <= stable_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign pub.o_result_stable = {stable_q, 5'b0};
    assign pub.o_valid         = valid_q;
    assign pub.o_overrun       = overrun_q;
    assign o_frame_count       = fcnt_q;
    assign o_state             = state_q;

endmodule

// File: tb/tb_color_result_stabilizer.sv
// Bench for color_result_stabilizer: vector table, directed corner sequences and a
// randomized run against a frame-history reference model.
module tb_color_result_stabilizer;

    localparam int SF = 4;
    localparam int FW = 8;
`ifdef STABILIZER_NOMATCH_REJECT_EN
    localparam bit REJECT_EN = 1'b1;
`else
    localparam bit REJECT_EN = 1'b0;
`endif

    localparam logic [31:0] VAL_A = 32'h2492_4920;
    localparam logic [31:0] VAL_B = 32'h4924_9240;
    localparam logic [31:0] VAL_C = 32'h6DB6_DB60;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          sof = 1'b0;
    logic [31:0]   res = '0;
    logic          en = 1'b0;
    logic [FW-1:0] fcnt;
    logic [1:0]    st;

    color_result_stabilizer_if bus();

    color_result_stabilizer #(.STABLE_FRAMES(SF), .FCNT_WIDTH(FW)) dut (
        .i_clk_125MHz  (clk),
        .db_rstn       (rstn),
        .i_sof         (sof),
        .i_result      (res),
        .i_enable      (en),
        .pub           (bus),
        .o_frame_count (fcnt),
        .o_state       (st)
    );

    always #4 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame history of the current tracking session.
    bit            m_track, m_pub, m_valid, m_ovr;
    logic [31:0]   m_stable;
    logic [FW-1:0] m_fcnt;
    int            m_hist[$];
    logic [31:0]   exp_q[$];

    function automatic bit has_nomatch(input logic [26:0] s);
        bit found = 1'b0;
        for (int r = 0; r < 9; r++) if (s[r*3 +: 3] == 3'b111) found = 1'b1;
        return found && REJECT_EN;
    endfunction

    task automatic model_reset();
        m_track = 0; m_pub = 0; m_valid = 0; m_ovr = 0;
        m_stable = '0; m_fcnt = '0;
        m_hist.delete();
        exp_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic [31:0] r, input logic e,
                              input logic a, input logic c, output bit p);
        int snap;
        int run;
        p = 1'b0;
        if (m_track) begin
            if (!e) begin
                m_track = 0;
                m_pub = 0;
                m_hist.delete();
            end else if (s) begin
                m_fcnt++;
                snap = int'(r[31:5]);
                if (has_nomatch(r[31:5])) begin
                    m_hist.push_back(-1);
                end else begin
                    m_hist.push_back(snap);
                    run = 0;
                    for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == snap; i--) run++;
                    p = (run >= SF) && (!m_pub || r[31:5] != m_stable[31:5]);
                end
                if (m_hist.size() > 300) void'(m_hist.pop_front());
            end
        end else if (e) begin
            m_track = 1;
        end
        m_ovr = (p && m_valid) ? 1'b1 : (c ? 1'b0 : m_ovr);
        m_valid = p ? 1'b1 : (a ? 1'b0 : m_valid);
        if (p) begin
            m_pub = 1;
            m_stable = {r[31:5], 5'b0};
            exp_q.push_back(m_stable);
        end
    endtask

    task automatic step(input logic s, input logic [31:0] r, input logic e,
                        input logic a, input logic c);
        bit p;
        logic [31:0] x;
        sof = s; res = r; en = e; bus.i_ack = a; bus.i_clr_overrun = c;
        @(posedge clk);
        model_edge(s, r, e, a, c, p);
        #1;
        chk("valid", 32'(bus.o_valid), 32'(m_valid));
        chk("result_stable", bus.o_result_stable, m_stable);
        chk("overrun", 32'(bus.o_overrun), 32'(m_ovr));
        chk("frame_count", 32'(fcnt), 32'(m_fcnt));
        chk("state", 32'(st), {31'd0, m_track});
        if (p) begin
            x = exp_q.pop_front();
            chk("publish_value", bus.o_result_stable, x);
        end
    endtask

    task automatic frame(input logic [31:0] r);
        step(1'b1, r, 1'b1, 1'b0, 1'b0);
        step(1'b0, r, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_result", bus.o_result_stable, 32'd0);
        chk("rst_overrun", 32'(bus.o_overrun), 32'd0);
        chk("rst_fcount", 32'(fcnt), 32'd0);
        chk("rst_state", 32'(st), 32'd0);
        model_reset();
        sof = 0; en = 0; bus.i_ack = 0; bus.i_clr_overrun = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct {
        logic        sof;
        logic [31:0] res;
        logic        en;
        logic        ack;
        logic        exp_valid;
        logic [31:0] exp_stable;
        logic [7:0]  exp_fcnt;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] r;
        bus.i_ack = 1'b0;
        bus.i_clr_overrun = 1'b0;
        model_reset();

        vecs[0] = '{1'b0, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0, 2'd1};
        vecs[1] = '{1'b1, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd1, 2'd1};
        vecs[2] = '{1'b0, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd1, 2'd1};
        vecs[3] = '{1'b1, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd2, 2'd1};
        vecs[4] = '{1'b0, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd2, 2'd1};
        vecs[5] = '{1'b1, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd3, 2'd1};
        vecs[6] = '{1'b0, VAL_A, 1'b1, 1'b0, 1'b0, 32'h0,  8'd3, 2'd1};
        vecs[7] = '{1'b1, VAL_A, 1'b1, 1'b0, 1'b1, VAL_A,  8'd4, 2'd1};
        vecs[8] = '{1'b0, VAL_A, 1'b1, 1'b1, 1'b0, VAL_A,  8'd4, 2'd1};
        vecs[9] = '{1'b1, VAL_A, 1'b1, 1'b0, 1'b0, VAL_A,  8'd5, 2'd1};

        #3;
        do_reset();

        // Stable A over four frames publishes one cycle after the fourth sof.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].sof, vecs[i].res, vecs[i].en, vecs[i].ack, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_stable", i), bus.o_result_stable, vecs[i].exp_stable);
            chk($sformatf("vec%0d_fcount", i), 32'(fcnt), 32'(vecs[i].exp_fcnt));
            chk($sformatf("vec%0d_state", i), 32'(st), 32'(vecs[i].exp_state));
        end

        // Alternating results never settle.
        do_reset();
        step(1'b0, VAL_A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) frame((i % 2 == 0) ? VAL_A : VAL_B);
        chk("alt_valid", 32'(bus.o_valid), 32'd0);
        chk("alt_fcount", 32'(fcnt), 32'd10);

        // No republish of a persisting result; a new stable value publishes.
        do_reset();
        step(1'b0, VAL_A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) frame(VAL_A);
        chk("t3_first_valid", 32'(bus.o_valid), 32'd1);
        step(1'b0, VAL_A, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) frame(VAL_A);
        chk("t3_no_repub", 32'(bus.o_valid), 32'd0);
        for (int i = 0; i < 4; i++) frame(VAL_C);
        chk("t3_b_valid", 32'(bus.o_valid), 32'd1);
        chk("t3_b_value", bus.o_result_stable, VAL_C);

        // Overrun: unacknowledged A overwritten by C, then cleared.
        do_reset();
        step(1'b0, VAL_A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) frame(VAL_A);
        for (int i = 0; i < 4; i++) frame(VAL_C);
        chk("t4_value", bus.o_result_stable, VAL_C);
        chk("t4_valid", 32'(bus.o_valid), 32'd1);
        chk("t4_overrun", 32'(bus.o_overrun), 32'd1);
        step(1'b0, VAL_C, 1'b1, 1'b0, 1'b1);
        chk("t4_clr", 32'(bus.o_overrun), 32'd0);

        // Publish and ack together: publish wins.
        for (int i = 0; i < 3; i++) frame(VAL_B);
        step(1'b1, VAL_B, 1'b1, 1'b1, 1'b0);
        chk("pub_ack_valid", 32'(bus.o_valid), 32'd1);

        // Padding bits ignored; asynchronous reset mid-run restarts the count.
        do_reset();
        step(1'b0, 32'h2492_493F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) frame(32'h2492_493F);
        step(1'b0, 32'h2492_493F, 1'b1, 1'b0, 1'b0);
        #2;
        do_reset();
        step(1'b0, 32'h2492_493F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) frame(32'h2492_493F);
        chk("t5_not_yet", 32'(bus.o_valid), 32'd0);
        frame(32'h2492_493F);
        chk("t5_value", bus.o_result_stable, VAL_A);

        // sof on the falling-enable cycle is ignored.
        step(1'b1, VAL_B, 1'b0, 1'b0, 1'b0);
        chk("dis_fcount", 32'(fcnt), 32'd4);
        chk("dis_state", 32'(st), 32'd0);

`ifdef STABILIZER_NOMATCH_REJECT_EN
        do_reset();
        r = VAL_A | (32'h7 << 17);
        step(1'b0, VAL_A, 1'b1, 1'b0, 1'b0);
        frame(VAL_A); frame(VAL_A); frame(r);
        for (int i = 0; i < 3; i++) frame(VAL_A);
        chk("t6_rejected", 32'(bus.o_valid), 32'd0);
        chk("t6_fcount", 32'(fcnt), 32'd6);
        frame(VAL_A);
        chk("t6_publish", 32'(bus.o_valid), 32'd1);
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0: r = VAL_A;
                1: r = VAL_B;
                default: r = VAL_C;
            endcase
            r[4:0] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) r = r | (32'h7 << (5 + 3 * $urandom_range(0, 8)));
            step(($urandom_range(0, 2) == 0), r, ($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/color_result_stabilizer.md
Name: color_result_stabilizer

Overview:
Consumes the 32-bit nine-region colour result produced by the colour-detection top level and publishes a debounced result to the processor side.
- The live result is snapshotted once per camera frame on the start-of-frame pulse.
- A result is published only after it has been identical for STABLE_FRAMES consecutive frames.
- Each publish is signalled with a valid/ack handshake, plus overrun and frame-count status.

Parameters:
STABLE_FRAMES, 4, consecutive identical frame snapshots required before publish; legal range 1..255.
FCNT_WIDTH, 16, width of free-running frame counter.

Ports:
i_clk_125MHz  in  1  system clock.
db_rstn  in  1  reset: asynchronous, active-low; clock i_clk_125MHz.
i_sof  in  1  start-of-frame pulse, one cycle wide, synchronous to i_clk_125MHz.
i_result  in  32  live result: nine 3-bit region codes in [31:5], region 0 at [31:29]; [4:0] are padding.
i_enable  in  1  tracking enable.
i_ack  in  1  processor acknowledge of the published result.
i_clr_overrun  in  1  clears o_overrun.
o_result_stable  out  32  last published result; [4:0] always 0.
o_valid  out  1  a published result is awaiting acknowledge.
o_overrun  out  1  sticky: a publish occurred while o_valid was already 1.
o_frame_count  out  FCNT_WIDTH  count of i_sof pulses seen while enabled; wraps.
o_state  out  2  current state: 0 = IDLE, 1 = TRACK.

Behaviour:
- Reset (db_rstn low): all outputs 0. Internal state is cleared: candidate = 0, match count = 0, published flag = 0, state = IDLE. Reset applies immediately (asynchronous) and is released synchronously.
- Comparison uses only i_result[31:5]. Bits [4:0] are ignored everywhere.
- State IDLE:
  - i_sof is ignored.
  - Moves to TRACK on the cycle after i_enable = 1.
- State TRACK:
  - i_enable = 0 -> back to IDLE on the next cycle. Match count and published flag are cleared. o_result_stable, o_valid and o_overrun are retained.
  - On an i_sof cycle, let snap = i_result[31:5]:
    - o_frame_count increments.
    - If snap equals the candidate and the match count is nonzero, the match count increments, saturating at STABLE_FRAMES.
    - Otherwise the candidate becomes snap and the match count becomes 1.
- Publish condition, evaluated on the same sof cycle using the updated values: updated match count == STABLE_FRAMES, AND (published flag = 0 OR candidate differs from o_result_stable[31:5]).
- On publish:
  - o_result_stable <= {candidate, 5'b0}.
  - o_valid <= 1.
  - published flag <= 1.
  - Visible on the cycle after the i_sof cycle (latency 1).
- A stable result that persists does not republish. A saturated match count stays at STABLE_FRAMES.
- STABLE_FRAMES = 1: every changed snapshot publishes on its first frame.
- Handshake:
  - i_ack while o_valid = 1 -> o_valid = 0 on the next cycle.
  - i_ack while o_valid = 0 has no effect.
  - Publish and i_ack in the same cycle: publish wins and o_valid stays 1.
- Overrun:
  - A publish while o_valid = 1 overwrites o_result_stable and sets o_overrun.
  - i_clr_overrun clears o_overrun on the next cycle. A simultaneous set wins over the clear.
- o_frame_count wraps from 2^FCNT_WIDTH-1 to 0.
- An i_sof pulse on the same cycle that i_enable falls is ignored; IDLE takes priority.

Optional Feature:
Macro STABILIZER_NOMATCH_REJECT_EN. Region code 3'b111 means "no colour matched".
- Defined: a snapshot containing any region code 3'b111 is rejected. The match count is cleared to 0, the candidate is unchanged, no publish occurs, and o_frame_count still increments.
- Undefined: code 3'b111 is treated like any other code.

Test Plan:
1. STABLE_FRAMES=4, i_result=0x24924920 held, four i_sof pulses -> o_valid=1 one cycle after the 4th pulse; o_result_stable=0x24924920; o_frame_count=4.
2. i_result alternating 0x24924920 / 0x49249240 on every frame for 10 frames -> o_valid stays 0; o_frame_count=10.
3. Publish A, pulse i_ack, hold A for 8 more frames -> no further o_valid. Switch to B=0x6DB6DB60 for 4 frames -> o_valid=1 and o_result_stable=B.
4. Publish A with no ack, then B stable for 4 frames -> o_result_stable=B, o_valid=1, o_overrun=1. Pulse i_clr_overrun -> o_overrun=0 next cycle.
5. i_result=0x2492493F (padding bits set): publishes 0x24924920. Reset pulse 2 cycles after the 3rd sof -> all outputs 0 immediately; a further 4 frames are needed before publish.
6. With STABILIZER_NOMATCH_REJECT_EN defined: region 4 code = 7 on the 3rd of 4 otherwise identical frames -> no publish until 4 further clean frames.
